axi_lite_reg_slave: RTL and testbench
=====================================

// Module: axi_lite_reg_slave
// PURPOSE
// - AXI4-Lite responder: NUM_REGS x 32-bit read/write register bank on the slave modport of axi_lite_if.
// - Sits at the peripheral end of the AXI4-Lite interconnect; presents registers to local logic as flat outputs.
// - Independent write (AW/W/B) and read (AR/R) engines; one outstanding transaction per direction.
// PARAMETERS
// - NUM_REGS   8             number of 32-bit registers (power of 2, >=2); byte offsets 0x00..(NUM_REGS*4-4)
// - RESET_VAL  32'h0000_0000 reset value loaded into every register
// PORTS
// - ACLK       in   1              clock, all logic rising-edge
// - ARESET     in   1              synchronous reset, active-high
// - s          --   axi_lite_if.slave  AW/W/B/AR/R channels, ADDR/DATA width 32
// - reg_out    out  NUM_REGS*32    register contents; reg i at [32*i +: 32]
// - wr_pulse   out  NUM_REGS       1-cycle strobe, bit i high in the cycle after reg i is written
// BEHAVIOUR
// - Reset (ARESET=1 at edge): regs=RESET_VAL; AWREADY=WREADY=ARREADY=1; BVALID=RVALID=0; BRESP=RRESP=0; RDATA=0; wr_pulse=0; held AW/W discarded.
// - Decode: idx = ADDR[2 +: log2(NUM_REGS)]; ADDR[1:0] ignored; ADDR >= NUM_REGS*4 -> out of range.
// - Write FSM: W_COLLECT -> W_RESP.
//   - W_COLLECT: AWREADY = !aw_held; WREADY = !w_held. AW and W accepted in either order or same cycle; each latched on its handshake.
//   - At the edge where the second of AW/W completes: commit write, BVALID<=1, go W_RESP (BVALID 1 cycle after last handshake).
//   - Commit: byte k of reg idx updated iff WSTRB[k]; WSTRB=0 -> no change, OKAY. wr_pulse[idx]=1 next cycle (even if WSTRB=0).
//   - Out of range: no register change, no wr_pulse, BRESP=2'b10 (SLVERR); else BRESP=2'b00.
//   - W_RESP: AWREADY=WREADY=0; hold BVALID/BRESP stable until BREADY; on BVALID&&BREADY -> clear held flags, W_COLLECT (ready again next cycle).
// - Read FSM: R_IDLE -> R_DATA.
//   - R_IDLE: ARREADY=1. On ARVALID: RDATA<=reg[idx] (or 0 + RRESP=2'b10 if out of range), RVALID<=1 next cycle, ARREADY<=0.
//   - R_DATA: hold RVALID/RDATA/RRESP until RREADY; on RVALID&&RREADY -> R_IDLE, ARREADY=1 next cycle.
// - Same-edge read handshake and write commit to same reg: read returns pre-write value.
// - Read and write engines never stall each other; no combinational ready/valid paths from inputs.
// - AWPROT/ARPROT ignored unless AXIL_PROT_CHECK_EN.
// - Reset mid-transaction: pending B/R dropped without completion; master must reissue.
// CONFIGURATION
// - AXIL_PROT_CHECK_EN defined: accesses with PROT[0]=0 (unprivileged) rejected: write -> no change, no wr_pulse,
//   BRESP=2'b10; read -> RDATA=0, RRESP=2'b10. Otherwise unchanged behaviour.
// - AXIL_PROT_CHECK_EN undefined: AWPROT/ARPROT unused, no PROT-based errors.
// TESTING
// - Reset, then read 0x04 -> RVALID 1 cycle after AR handshake, RDATA=RESET_VAL, RRESP=00, reg_out all RESET_VAL.
// - AW 0x08 and W 0xDEAD_BEEF/STRB 4'hF same cycle -> BVALID next cycle, BRESP=00, wr_pulse[2]=1 one cycle, reg2=0xDEADBEEF.
// - W first (0x1122_3344, STRB 4'b0101), AW 0x08 three cycles later -> reg2=0xDE22BE44; BVALID held 4 cycles while BREADY=0, AWREADY/WREADY=0.
// - Write 0x20 (NUM_REGS=8) -> BRESP=10, no reg change/no wr_pulse; read 0x20 -> RDATA=0, RRESP=10.
// - Read 0x08 handshake on same edge as write commit to 0x08 (0x5555_5555) -> RDATA=old 0xDE22BE44; subsequent read -> 0x55555555.
// - ARESET asserted while BVALID=1 and RVALID=1 -> both 0 next cycle, regs=RESET_VAL; with AXIL_PROT_CHECK_EN, write AWPROT=3'b000 -> BRESP=10.

Source files
------------

// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite channel bundle (32-bit address/data) shared by master and slave ends.
interface axi_lite_if;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS x 32-bit, independent write/read engines.
// Optional AXIL_PROT_CHECK_EN rejects unprivileged (PROT[0]=0) accesses with SLVERR.
module axi_lite_reg_slave #(
   parameter int          NUM_REGS  = 8,
   parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
   input  logic                   ACLK,
   input  logic                   ARESET,
   axi_lite_if.slave              s,
   output logic [NUM_REGS*32-1:0] reg_out,
   output logic [NUM_REGS-1:0]    wr_pulse
);
   localparam int IW = $clog2(NUM_REGS);

   typedef enum logic {W_COLLECT, W_RESP} wst_t;
   typedef enum logic {R_IDLE, R_DATA}    rst_t;

   logic [NUM_REGS-1:0][31:0] regs;
   wst_t        wst;
   rst_t        rstate;
   logic        aw_held, w_held;
   logic [31:0] awaddr_q, wdata_q;
   logic [3:0]  wstrb_q;
   logic [2:0]  awprot_q;
   logic        awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
   logic [1:0]  bresp_q, rresp_q;
   logic [31:0] rdata_q;

   logic          aw_hs, w_hs, commit, wr_ok, rd_ok;
   logic [31:0]   waddr, wdata;
   logic [3:0]    wstrb;
   logic [2:0]    wprot;
   logic [IW-1:0] widx, ridx;

   assign s.awready = awready_q;
   assign s.wready  = wready_q;
   assign s.bvalid  = bvalid_q;
   assign s.bresp   = bresp_q;
   assign s.arready = arready_q;
   assign s.rvalid  = rvalid_q;
   assign s.rresp   = rresp_q;
   assign s.rdata   = rdata_q;
   assign reg_out   = regs;

   // ready flags are only high in W_COLLECT with the matching half not yet held
   assign aw_hs  = s.awvalid && awready_q;
   assign w_hs   = s.wvalid && wready_q;
   assign commit = (wst == W_COLLECT) && (aw_held || aw_hs) && (w_held || w_hs);
   assign waddr  = aw_held ? awaddr_q : s.awaddr;
   assign wprot  = aw_held ? awprot_q : s.awprot;
   assign wdata  = w_held  ? wdata_q  : s.wdata;
   assign wstrb  = w_held  ? wstrb_q  : s.wstrb;
   assign widx   = waddr[2 +: IW];
   assign ridx   = s.araddr[2 +: IW];

`ifdef AXIL_PROT_CHECK_EN
   assign wr_ok = (waddr[31:2+IW] == '0) && wprot[0];
   assign rd_ok = (s.araddr[31:2+IW] == '0) && s.arprot[0];
`else
   assign wr_ok = (waddr[31:2+IW] == '0);
   assign rd_ok = (s.araddr[31:2+IW] == '0);
`endif

   logic unused_bits;
   assign unused_bits = ^{waddr[1:0], s.araddr[1:0], wprot, s.arprot};

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         regs      <= {NUM_REGS{RESET_VAL}};
         wst       <= W_COLLECT;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         awaddr_q  <= '0;
         awprot_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awready_q <= 1'b1;
         wready_q  <= 1'b1;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         wr_pulse  <= '0;
      end else begin
         wr_pulse <= '0;
         case (wst)
            W_COLLECT: begin
               if (aw_hs) begin
                  awaddr_q  <= s.awaddr;
                  awprot_q  <= s.awprot;
                  aw_held   <= 1'b1;
                  awready_q <= 1'b0;
               end
               if (w_hs) begin
                  wdata_q  <= s.wdata;
                  wstrb_q  <= s.wstrb;
                  w_held   <= 1'b1;
                  wready_q <= 1'b0;
               end
               if (commit) begin
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= wr_ok ? 2'b00 : 2'b10;
                  wst       <= W_RESP;
                  if (wr_ok) begin
                     for (int k = 0; k < 4; k++)
                        if (wstrb[k]) regs[widx][8*k +: 8] <= wdata[8*k +: 8];
                     wr_pulse[widx] <= 1'b1;
                  end
               end
            end
            W_RESP: begin
               if (s.bready) begin
                  bvalid_q  <= 1'b0;
                  aw_held   <= 1'b0;
                  w_held    <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  wst       <= W_COLLECT;
               end
            end
         endcase
      end
   end

   // regs is sampled before this edge's write lands, so a same-edge read sees the old value
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rstate    <= R_IDLE;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= 2'b00;
      end else begin
         case (rstate)
            R_IDLE: begin
               if (s.arvalid) begin
                  rdata_q   <= rd_ok ? regs[ridx] : 32'h0;
                  rresp_q   <= rd_ok ? 2'b00 : 2'b10;
                  rvalid_q  <= 1'b1;
                  arready_q <= 1'b0;
                  rstate    <= R_DATA;
               end
            end
            R_DATA: begin
               if (s.rready) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  rstate    <= R_IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: scoreboard queues for B/R responses plus
// a register-bank model compared against reg_out.
module tb_axi_lite_reg_slave;
   localparam logic [31:0] RV = 32'h1234_5678;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [255:0]          reg_out;
   logic [7:0]            wr_pulse;
   logic [7:0][31:0]      mdl;
   logic [1:0]            bq[$];
   logic [33:0]           rq[$];
   int                    checks = 0;
   int                    errors = 0;

   axi_lite_if bus();

   axi_lite_reg_slave #(.NUM_REGS(8), .RESET_VAL(RV)) dut (
      .ACLK(clk), .ARESET(rst), .s(bus), .reg_out(reg_out), .wr_pulse(wr_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] strb);
      logic [31:0] r = old;
      for (int k = 0; k < 4; k++) if (strb[k]) r[8*k +: 8] = d[8*k +: 8];
      return r;
   endfunction

   // Called just after a rising edge; returns just after a rising edge.
   task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [2:0] prot, input int aw_lag, input int b_lag,
                            input logic [1:0] exp_resp, input int pidx);
      bit ad = 0, wd = 0, ah, wh;
      int c = 0;
      logic [7:0] mask = (pidx >= 0) ? 8'(1 << pidx) : 8'h00;
      bq.push_back(exp_resp);
      bus.awaddr = addr; bus.awprot = prot; bus.wdata = data; bus.wstrb = strb;
      bus.wvalid = 1'b1;
      while (!(ad && wd) && c < 50) begin
         if (c == aw_lag && !ad) bus.awvalid = 1'b1;
         @(negedge clk);
         ah = bus.awvalid && bus.awready;
         wh = bus.wvalid && bus.wready;
         @(posedge clk); #1;
         if (ah) begin ad = 1; bus.awvalid = 1'b0; end
         if (wh) begin wd = 1; bus.wvalid = 1'b0; end
         c++;
      end
      check("aw_w_handshake", {ad, wd}, 2'b11);
      @(negedge clk);
      check("bvalid_latency", bus.bvalid, 1'b1);
      check("wr_pulse", wr_pulse, mask);
      for (int i = 0; i < b_lag; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("b_hold", {bus.bvalid, bus.awready, bus.wready}, 3'b100);
      end
      bus.bready = 1'b1;
      c = 0;
      while (!bus.bvalid && c < 20) begin @(negedge clk); c++; end
      if (bq.size() == 0) check("bq_empty", 1'b1, 1'b0);
      else check("bresp", {bus.bvalid, bus.bresp}, {1'b1, bq.pop_front()});
      @(posedge clk); #1;
      bus.bready = 1'b0;
      @(negedge clk);
      check("w_ready_again", {bus.awready, bus.wready, bus.bvalid, wr_pulse}, {3'b110, 8'h00});
      @(posedge clk); #1;
   endtask

   task automatic read_txn(input logic [31:0] addr, input logic [2:0] prot,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
      bit h = 0;
      int c = 0;
      rq.push_back({exp_data, exp_resp});
      bus.araddr = addr; bus.arprot = prot; bus.arvalid = 1'b1;
      while (!h && c < 50) begin
         @(negedge clk);
         h = bus.arvalid && bus.arready;
         @(posedge clk); #1;
         c++;
      end
      bus.arvalid = 1'b0;
      check("ar_handshake", h, 1'b1);
      @(negedge clk);
      check("rvalid_latency", bus.rvalid, 1'b1);
      if (rq.size() == 0) check("rq_empty", 1'b1, 1'b0);
      else check("rdata_rresp", {bus.rdata, bus.rresp}, rq.pop_front());
      bus.rready = 1'b1;
      @(posedge clk); #1;
      bus.rready = 1'b0;
      @(negedge clk);
      check("ar_ready_again", {bus.arready, bus.rvalid}, 2'b10);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      mdl = {8{RV}};
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
      check("rst_valid", {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, bus.rdata}, '0);
      check("rst_regs", reg_out, mdl);
      check("rst_pulse", wr_pulse, 8'h00);
      @(posedge clk); #1;

      read_txn(32'h04, 3'b001, RV, 2'b00);

      write_txn(32'h08, 32'hDEAD_BEEF, 4'hF, 3'b001, 0, 0, 2'b00, 2);
      mdl[2] = merge(mdl[2], 32'hDEAD_BEEF, 4'hF);
      check("regs_full_wr", reg_out, mdl);

      write_txn(32'h08, 32'h1122_3344, 4'b0101, 3'b001, 3, 4, 2'b00, 2);
      mdl[2] = merge(mdl[2], 32'h1122_3344, 4'b0101);
      check("reg2_strobed", reg_out[95:64], 32'hDE22_BE44);
      check("regs_strobed", reg_out, mdl);

      // ADDR[1:0] ignored, and a zero strobe still pulses without changing data
      write_txn(32'h0E, 32'hA0B1_C2D3, 4'h3, 3'b001, 0, 1, 2'b00, 3);
      mdl[3] = merge(mdl[3], 32'hA0B1_C2D3, 4'h3);
      write_txn(32'h1C, 32'hFFFF_FFFF, 4'h0, 3'b001, 0, 0, 2'b00, 7);
      check("regs_nostrb", reg_out, mdl);
      read_txn(32'h0D, 3'b001, mdl[3], 2'b00);

      write_txn(32'h20, 32'hFFFF_FFFF, 4'hF, 3'b001, 0, 0, 2'b10, -1);
      check("regs_oor", reg_out, mdl);
      read_txn(32'h20, 3'b001, 32'h0, 2'b10);

      fork
         write_txn(32'h08, 32'h5555_5555, 4'hF, 3'b001, 0, 0, 2'b00, 2);
         read_txn(32'h08, 3'b001, mdl[2], 2'b00);
      join
      mdl[2] = merge(mdl[2], 32'h5555_5555, 4'hF);
      read_txn(32'h08, 3'b001, 32'h5555_5555, 2'b00);

      // reset while both responses are pending
      bus.awaddr = 32'h04; bus.awprot = 3'b001; bus.wdata = 32'h0BAD_0BAD; bus.wstrb = 4'hF;
      bus.araddr = 32'h00; bus.arprot = 3'b001;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
      @(posedge clk); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      @(negedge clk);
      check("pending_br", {bus.bvalid, bus.rvalid}, 2'b11);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      mdl = {8{RV}};
      @(negedge clk);
      check("midrst_valid", {bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready}, 5'b00111);
      check("midrst_regs", reg_out, mdl);
      @(posedge clk); #1;

`ifdef AXIL_PROT_CHECK_EN
      write_txn(32'h0C, 32'hCAFE_F00D, 4'hF, 3'b000, 0, 0, 2'b10, -1);
      check("prot_regs", reg_out, mdl);
      read_txn(32'h04, 3'b000, 32'h0, 2'b10);
`else
      write_txn(32'h0C, 32'hCAFE_F00D, 4'hF, 3'b000, 0, 0, 2'b00, 3);
      mdl[3] = merge(mdl[3], 32'hCAFE_F00D, 4'hF);
      check("prot_regs", reg_out, mdl);
      read_txn(32'h0C, 3'b000, 32'hCAFE_F00D, 2'b00);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
